// File: rtl/md_pkg.sv
// Shared types for the iterative multiply/divide unit: FSM state encoding and
// Booth recode selects.
package md_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMult = 2'b01,
        StDiv  = 2'b10,
        StDone = 2'b11
    } md_state_e;

    typedef enum logic [2:0] {
        BoothZero   = 3'd0,
        BoothPlus1  = 3'd1,
        BoothPlus2  = 3'd2,
        BoothMinus1 = 3'd3,
        BoothMinus2 = 3'd4
    } booth_sel_e;

endpackage

// File: rtl/md_booth_encoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
// to a partial-product select and a negate flag.
module md_booth_encoder
    import md_pkg::*;
(
    input  logic [2:0] window_i,
    output booth_sel_e sel_o,
    output logic       neg_o
);

    always_comb begin
        sel_o = BoothZero;
        neg_o = 1'b0;
        case (window_i)
            3'b001, 3'b010: sel_o = BoothPlus1;
            3'b011:         sel_o = BoothPlus2;
            3'b100: begin
                sel_o = BoothMinus2;
                neg_o = 1'b1;
            end
            3'b101, 3'b110: begin
                sel_o = BoothMinus1;
                neg_o = 1'b1;
            end
            default:        sel_o = BoothZero;
        endcase
    end

endmodule

// File: rtl/iter_multdiv.sv
// Iterative signed multiply (radix-4 Booth, WIDTH/2 steps) and divide
// (non-restoring on magnitudes, WIDTH steps) with registered outputs.
module iter_multdiv
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth  // must be even and >= 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned MULT_STEPS = WIDTH / 2;
    localparam int unsigned DIV_STEPS  = WIDTH;
    localparam int unsigned CNT_W      = $clog2(DIV_STEPS);
    localparam int unsigned ACC_W      = 2 * WIDTH + 3;
    localparam int unsigned REM_W      = WIDTH + 2;
    localparam logic [CNT_W-1:0] LastMult = CNT_W'(MULT_STEPS - 1);
    localparam logic [CNT_W-1:0] LastDiv  = CNT_W'(DIV_STEPS - 1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    // Booth accumulator {hi[WIDTH+1:0], multiplier[WIDTH-1:0], appended 0};
    // product bits shift in from the top as multiplier bits are consumed.
    logic [ACC_W-1:0] acc_q;
    logic [WIDTH-1:0] m_q;
    logic [REM_W-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] den_q;
    logic             sign_q;
    logic             div_zero_q;
    logic             div_ovf_q;
    logic [WIDTH-1:0] res_q;
    logic             exc_q;
    logic             rdy_q;

    booth_sel_e booth_sel;
    logic       booth_neg;

    md_booth_encoder u_booth_encoder (
        .window_i (acc_q[2:0]),
        .sel_o    (booth_sel),
        .neg_o    (booth_neg)
    );

    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] pp_mag;
    logic [WIDTH+1:0] pp;
    logic [WIDTH+1:0] hi_sum;
    logic [ACC_W-1:0] acc_step;
    logic             mul_ovf;

    always_comb begin
        m_ext = {{2{m_q[WIDTH-1]}}, m_q};
        case (booth_sel)
            BoothPlus1, BoothMinus1: pp_mag = m_ext;
            BoothPlus2, BoothMinus2: pp_mag = m_ext << 1;
            default:                 pp_mag = '0;
        endcase
        pp       = booth_neg ? -pp_mag : pp_mag;
        hi_sum   = acc_q[ACC_W-1:WIDTH+1] + pp;
        acc_step = {{2{hi_sum[WIDTH+1]}}, hi_sum, acc_q[WIDTH:2]};
        // Product sits in acc_step[2W:1]; overflow if the high half is not a sign copy.
        mul_ovf  = acc_step[2*WIDTH:WIDTH+1] != {WIDTH{acc_step[WIDTH]}};
    end

    logic [REM_W-1:0] rem_shift;
    logic [REM_W-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] quo_signed;
    logic [WIDTH-1:0] div_res;
    logic             div_exc;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        rem_shift  = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
        rem_step   = rem_q[REM_W-1] ? rem_shift + {2'b00, den_q}
                                    : rem_shift - {2'b00, den_q};
        quo_step   = {quo_q[WIDTH-2:0], ~rem_step[REM_W-1]};
        quo_signed = sign_q ? -quo_step : quo_step;
        div_res    = div_zero_q ? '0 : quo_signed;
        div_exc    = div_zero_q | div_ovf_q;
        // -MIN_INT wraps to MIN_INT, which is the correct unsigned magnitude.
        a_mag      = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_mag      = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            m_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            den_q      <= '0;
            sign_q     <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            res_q      <= '0;
            exc_q      <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (ctrl_MULT) begin
                state_q <= StMult;
                cnt_q   <= '0;
                m_q     <= data_operandA;
                acc_q   <= {{(WIDTH + 2){1'b0}}, data_operandB, 1'b0};
            end else if (ctrl_DIV) begin
                state_q    <= StDiv;
                cnt_q      <= '0;
                rem_q      <= '0;
                quo_q      <= a_mag;
                den_q      <= b_mag;
                sign_q     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero_q <= data_operandB == '0;
                div_ovf_q  <= (data_operandA == {1'b1, {(WIDTH - 1){1'b0}}}) &&
                              (data_operandB == {WIDTH{1'b1}});
            end else begin
                case (state_q)
                    StMult: begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastMult) begin
                            state_q <= StDone;
                            res_q   <= acc_step[WIDTH:1];
                            exc_q   <= mul_ovf;
                            rdy_q   <= 1'b1;
                        end
                    end
                    StDiv: begin
                        rem_q <= rem_step;
                        quo_q <= quo_step;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastDiv) begin
                            state_q <= StDone;
                            res_q   <= div_res;
                            exc_q   <= div_exc;
                            rdy_q   <= 1'b1;
                        end
                    end
                    StDone:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: doc/iter_multdiv.md
Name: iter_multdiv

Overview:
- Iterative signed 32-bit multiply/divide unit.
- Consumed by the X stage of the 5-stage pipeline for mul/div ALU ops. X stage selects `data_result` in place of the ALU output and holds the pipeline stalled until `data_resultRDY`.
- Multiply uses radix-4 Booth recoding: WIDTH/2 steps.
- Divide uses non-restoring division on magnitudes with sign fix-up: WIDTH steps.

Parameters:
- WIDTH, 32, operand/result width; must be even and ≥4.
- MULT_STEPS, WIDTH/2, Booth iterations (derived, not overridable).
- DIV_STEPS, WIDTH, divide iterations (derived, not overridable).

Ports:
- clock  in  1  master clock, rising-edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- data_operandA  in  WIDTH  multiplicand / dividend, two's complement.
- data_operandB  in  WIDTH  multiplier / divisor, two's complement.
- ctrl_MULT  in  1  start-multiply pulse; operands sampled on the same edge.
- ctrl_DIV  in  1  start-divide pulse; operands sampled on the same edge.
- data_result  out  WIDTH  registered result; holds its value until the next completion.
- data_exception  out  1  registered; valid with data_resultRDY and held after it.
- data_resultRDY  out  1  one-cycle completion strobe.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; counter = 0.
  - data_result = 0, data_exception = 0, data_resultRDY = 0.
  - Internal accumulators cleared.
  - An operation in progress is abandoned; no RDY is ever produced for it.
- States: IDLE, MULT, DIV, DONE.
  - DONE lasts exactly one cycle and is the only state with data_resultRDY = 1.
- Start rules, evaluated on each rising edge:
  - If ctrl_MULT = 1: capture operands, counter = 0, go to MULT.
  - Else if ctrl_DIV = 1: capture operands, counter = 0, go to DIV.
  - MULT has priority when both are high.
  - Start is accepted in any state. A start in MULT/DIV aborts the current op and restarts with the new operands; the aborted op never produces RDY.
  - A start in DONE still lets RDY stay high for that cycle (the finished op's result), and the new op begins.
- MULT:
  - Each edge performs one Booth step: recode a 3-bit window of the multiplier to {0, ±M, ±2M}, add to the 2·WIDTH+1-bit product accumulator, then shift arithmetic right by 2.
  - After MULT_STEPS steps, go to DONE.
  - data_result = low WIDTH bits of the product.
  - data_exception = 1 iff the upper WIDTH bits ≠ the sign-extension of bit WIDTH-1 (signed overflow).
- DIV:
  - At capture, take |A| and |B|, and record sign = A[msb]^B[msb].
  - Each edge performs one non-restoring shift/add-or-subtract step.
  - After DIV_STEPS steps, go to DONE.
  - Quotient truncates toward zero and is negated when sign = 1. Remainder is discarded.
  - Divide by zero: result 0, exception 1, same fixed latency.
  - MIN_INT / -1: result 0x80000000, exception 1.
- Latency, counted from the capture edge E0:
  - Multiply: data_result and data_exception update on edge E16 (32-bit); RDY is high between E16 and E17.
  - Divide: data_result and data_exception update on edge E32; RDY is high between E32 and E33.
- DONE to IDLE on the next edge unless a start is present.
- Outputs are registered only. No combinational path from any input to any output.
- data_result and data_exception change only when entering DONE or on reset.

Decomposition:
- Shared package `md_pkg`:
  - State encoding constants (IDLE=2'b00, MULT=2'b01, DIV=2'b10, DONE=2'b11).
  - Booth recode select constants (ZERO, PLUS1, PLUS2, MINUS1, MINUS2).
  - Default WIDTH.
- One sub-module, `md_booth_encoder`: combinational, 3-bit window in, {select, negate} out. Instantiated once in the MULT datapath.
- Divider step and sign fix-up stay inline.

Test Plan:
- Multiply, negative operand: A=7, B=-3 (0xFFFFFFFD), ctrl_MULT for 1 cycle -> data_result=0xFFFFFFEB, exception=0. RDY high exactly 1 cycle, 16 cycles after the capture edge.
- Multiply overflow: A=0x00010000, B=0x00010000 -> data_result=0x00000000, exception=1. A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF, exception=0.
- Divide signs: -7/2 -> 0xFFFFFFFD; 100/-7 -> 0xFFFFFFF2; -100/-7 -> 0x0000000E. Each with exception=0 and RDY 32 cycles after capture.
- Divide exceptions: 5/0 -> result 0, exception=1, RDY at 32 cycles. 0x80000000/-1 -> result 0x80000000, exception=1.
- Restart and priority:
  - Start 3*4; at cycle 5 pulse ctrl_DIV with 20/4 -> no RDY at cycle 16; RDY 32 cycles after the second capture with result 5.
  - ctrl_MULT and ctrl_DIV both high with 6,3 -> result 18 at 16 cycles.
- Reset mid-op: start 1000/10, drive reset=0 asynchronously at cycle 8 -> all outputs 0 immediately with no clock edge, and no RDY ever appears. After release, 9*9 -> 81 with standard latency.
